// File: rtl/alu_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   state_t    : arbiter FSM states
//   MUL_W      : operand width of the shared 4x4 multiplier
//   REQ0, REQ1 : requester ids, also used as the round-robin pointer values
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MUL_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bit4multiplier.sv
// Combinational unsigned 4x4 multiplier with a full 8-bit result.
//   multiplicand     in  4 : operand a
//   multiplier_input in  4 : operand b
//   A_B              out 8 : a * b
module bit4multiplier (
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier_input,
    output logic [7:0] A_B
);

    // Zero-extend before multiplying so the result keeps all 8 bits.
    assign A_B = {4'b0000, multiplicand} * {4'b0000, multiplier_input};

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one bit4multiplier between two requesters using valid/ready
// handshakes and round-robin arbitration. Each product is registered and
// returned on the owning requester's response channel.
//   clk, rst_n                  : clock, async active-low reset
//   reqX_valid/ready/a/b        : request channel of requester X
//   rspX_valid/ready/product    : response channel of requester X
//   busy                        : registered, high in CALC and RESP
//   op_count                    : completed responses, wraps
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate, accept one request, latch operands and id
// CALC  | latched operands drive the multiplier, product registered
// RESP  | product offered to the latched requester until it is taken
module mul_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_W,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [2*WIDTH-1:0] rsp0_product,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [2*WIDTH-1:0] rsp1_product,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    state_t             state;
    state_t             state_nxt;
    logic               last_served;
    logic               grant;
    logic               lat_id;
    logic [WIDTH-1:0]   lat_a;
    logic [WIDTH-1:0]   lat_b;
    logic [2*WIDTH-1:0] mul_out;
    logic [2*WIDTH-1:0] prod_q;
    logic               busy_q;
    logic [CNT_W-1:0]   count_q;
    logic               req_hs;
    logic               rsp_hs;

    bit4multiplier u_mul (
        .multiplicand     (lat_a),
        .multiplier_input (lat_b),
        .A_B              (mul_out)
    );

    // A lone valid wins outright; on a tie (or with nothing pending) the
    // grant points at whichever requester was not served last.
    always_comb begin
        grant = ~last_served;
        if (req0_valid && !req1_valid) begin
            grant = REQ0;
        end else if (req1_valid && !req0_valid) begin
            grant = REQ1;
        end
    end

    // rst_n is folded in so both readies are low while reset is held.
    assign req0_ready = (state == IDLE) && (grant == REQ0) && rst_n;
    assign req1_ready = (state == IDLE) && (grant == REQ1) && rst_n;
    assign req_hs     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid   = (state == RESP) && (lat_id == REQ0);
    assign rsp1_valid   = (state == RESP) && (lat_id == REQ1);
    assign rsp0_product = rsp0_valid ? prod_q : '0;
    assign rsp1_product = rsp1_valid ? prod_q : '0;
    assign rsp_hs       = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign busy     = busy_q;
    assign op_count = count_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= REQ1;
            lat_id      <= REQ0;
            lat_a       <= '0;
            lat_b       <= '0;
            prod_q      <= '0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state  <= state_nxt;
            // busy follows the state being entered, so it is high exactly
            // while the registered state is CALC or RESP.
            busy_q <= (state_nxt != IDLE);
            if (state == IDLE && req_hs) begin
                lat_id <= grant;
                lat_a  <= (grant == REQ1) ? req1_a : req0_a;
                lat_b  <= (grant == REQ1) ? req1_b : req0_b;
            end
            if (state == CALC) begin
                prod_q <= mul_out;
            end
            if (rsp_hs) begin
                last_served <= lat_id;
                count_q     <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_product, rsp1_product;
    logic       busy;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: who was served last and how many responses completed.
    int m_last  = 1;
    int m_count = 0;

    mul_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_product (rsp0_product),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_product (rsp1_product),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int m_pick(bit v0, bit v1);
        if (v0 && v1) return (m_last == 1) ? 0 : 1;
        if (v1) return 1;
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request with both response readies high and reports what it observed.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          output int hs_id, output int lat, output int rsp_id,
                          output logic [7:0] prod, output bit to, output bit both_rdy);
        int hs_cyc;
        bit found;
        hs_id = -1; lat = -1; rsp_id = -1; prod = '0; to = 1'b0; both_rdy = 1'b0;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_rdy = 1'b1;
            if (req0_valid && req0_ready) begin hs_id = 0; found = 1'b1; end
            else if (req1_valid && req1_ready) begin hs_id = 1; found = 1'b1; end
        end
        if (!found) begin
            to = 1'b1;
            return;
        end
        hs_cyc = cyc;
        tick;
        if (hs_id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_rdy = 1'b1;
            if (rsp0_valid) begin
                rsp_id = rsp1_valid ? 2 : 0; prod = rsp0_product; found = 1'b1;
            end else if (rsp1_valid) begin
                rsp_id = 1; prod = rsp1_product; found = 1'b1;
            end
        end
        lat = cyc - hs_cyc;
        tick;
        if (!found) to = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick; tick;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if ({rsp0_product, rsp1_product, op_count} !== 24'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000", {rsp0_product, rsp1_product, op_count});
        end
        rst_n = 1'b1;
        m_last = 1; m_count = 0;
    endtask

    task automatic test_simultaneous;
        bit v0s[3] = '{1'b1, 1'b0, 1'b1};
        int hs_id, lat, rsp_id, exp_id;
        logic [7:0] prod, exp_p;
        bit to, both;
        for (int i = 0; i < 3; i++) begin
            exp_id = m_pick(v0s[i], 1'b1);
            exp_p  = (exp_id == 0) ? 8'd30 : 8'd14;
            run_op(v0s[i], 1'b1, 4'd5, 4'd6, 4'd7, 4'd2, hs_id, lat, rsp_id, prod, to, both);
            m_last = exp_id; m_count = (m_count + 1) % 256;
            checks++;
            if (to || hs_id != exp_id || rsp_id != exp_id) begin
                failures++;
                $display("FAIL sim_order[%0d] to=%0d hs=%0d rsp=%0d exp=%0d", i, to, hs_id, rsp_id, exp_id);
            end
            checks++;
            if (prod !== exp_p || lat != 2 || both) begin
                failures++;
                $display("FAIL sim_prod[%0d] got=%0d lat=%0d both=%0d exp=%0d lat=2", i, prod, lat, both, exp_p);
            end
            checks++;
            if (op_count !== 8'(m_count)) begin
                failures++;
                $display("FAIL sim_count[%0d] got=%0d exp=%0d", i, op_count, m_count);
            end
        end
    endtask

    task automatic test_single;
        int hs_id, lat, rsp_id;
        logic [7:0] prod;
        bit to, both;
        run_op(1'b1, 1'b0, 4'd3, 4'd2, 4'd0, 4'd0, hs_id, lat, rsp_id, prod, to, both);
        m_last = 0; m_count = (m_count + 1) % 256;
        checks++;
        if (to || hs_id != 0 || rsp_id != 0 || lat != 2) begin
            failures++;
            $display("FAIL single_path to=%0d hs=%0d rsp=%0d lat=%0d exp hs=0 rsp=0 lat=2", to, hs_id, rsp_id, lat);
        end
        checks++;
        if (prod !== 8'd6) begin
            failures++;
            $display("FAIL single_prod got=%0d exp=6", prod);
        end
        checks++;
        if (op_count !== 8'(m_count)) begin
            failures++;
            $display("FAIL single_count got=%0d exp=%0d", op_count, m_count);
        end
    endtask

    task automatic test_random;
        int hs_id, lat, rsp_id, exp_id;
        logic [7:0] prod, exp_p;
        logic [3:0] a0, b0, a1, b1;
        bit v0, v1, to, both;
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            exp_id = m_pick(v0, v1);
            exp_p  = (exp_id == 0) ? 8'(int'(a0) * int'(b0)) : 8'(int'(a1) * int'(b1));
            run_op(v0, v1, a0, b0, a1, b1, hs_id, lat, rsp_id, prod, to, both);
            m_last = exp_id; m_count = (m_count + 1) % 256;
            checks++;
            if (to || rsp_id != exp_id || prod !== exp_p || lat != 2 || both) begin
                failures++;
                $display("FAIL rand[%0d] to=%0d rsp=%0d prod=%0d lat=%0d both=%0d exp rsp=%0d prod=%0d",
                         i, to, rsp_id, prod, lat, both, exp_id, exp_p);
            end
            checks++;
            if (op_count !== 8'(m_count)) begin
                failures++;
                $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, op_count, m_count);
            end
        end
    endtask

    task automatic test_back_pressure;
        int hs_id, lat, rsp_id;
        logic [7:0] prod;
        bit to, both, found;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req1_valid && req1_ready) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL bp_req_hs got=timeout exp=handshake"); end
        tick;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rsp1_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL bp_rsp_valid got=timeout exp=valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_product !== 8'd225 || rsp0_valid !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] v1=%b p1=%0d v0=%b r0=%b r1=%b busy=%b exp v1=1 p1=225 v0=0 r=0 busy=1",
                         i, rsp1_valid, rsp1_product, rsp0_valid, req0_ready, req1_ready, busy);
            end
        end
        rsp1_ready = 1'b1;
        tick;
        m_last = 1; m_count = (m_count + 1) % 256;
        checks++;
        if (rsp1_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'(m_count) || req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release v1=%b busy=%b cnt=%0d r0=%b exp v1=0 busy=0 cnt=%0d r0=1",
                     rsp1_valid, busy, op_count, req0_ready, m_count);
        end
        run_op(1'b1, 1'b0, 4'd4, 4'd4, 4'd0, 4'd0, hs_id, lat, rsp_id, prod, to, both);
        m_last = 0; m_count = (m_count + 1) % 256;
        checks++;
        if (to || rsp_id != 0 || prod !== 8'd16 || op_count !== 8'(m_count)) begin
            failures++;
            $display("FAIL bp_waiter to=%0d rsp=%0d prod=%0d cnt=%0d exp rsp=0 prod=16 cnt=%0d",
                     to, rsp_id, prod, op_count, m_count);
        end
    endtask

    task automatic test_reset_mid;
        int hs_id, lat, rsp_id;
        logic [7:0] prod;
        bit to, both, found, seen;
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd5; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rmid_req_hs got=timeout exp=handshake"); end
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0
            || {rsp0_product, rsp1_product, op_count} !== 24'd0) begin
            failures++;
            $display("FAIL rmid_clear ctrl=%b data=%h exp ctrl=00000 data=000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, {rsp0_product, rsp1_product, op_count});
        end
        tick;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        m_last = 1; m_count = 0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || rsp0_product == 8'd45) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rmid_ghost got=response exp=none"); end
        tick;
        run_op(1'b1, 1'b0, 4'd9, 4'd5, 4'd0, 4'd0, hs_id, lat, rsp_id, prod, to, both);
        m_last = 0; m_count = (m_count + 1) % 256;
        checks++;
        if (to || rsp_id != 0 || prod !== 8'd45 || lat != 2 || op_count !== 8'(m_count)) begin
            failures++;
            $display("FAIL rmid_after to=%0d rsp=%0d prod=%0d lat=%0d cnt=%0d exp rsp=0 prod=45 lat=2 cnt=%0d",
                     to, rsp_id, prod, lat, op_count, m_count);
        end
    endtask

    task automatic test_withdrawal;
        bit found, bad;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3;
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req1_valid && req1_ready) found = 1'b1;
        end
        tick;
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && !(rsp1_valid === 1'b1); i++) @(negedge clk);
        checks++;
        if (!found || rsp1_valid !== 1'b1 || rsp1_product !== 8'd6) begin
            failures++;
            $display("FAIL wd_resp hs=%0d v1=%b p1=%0d exp hs=1 v1=1 p1=6", found, rsp1_valid, rsp1_product);
        end
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd7;
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) bad = 1'b1;
        end
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        tick;
        m_last = 1; m_count = (m_count + 1) % 256;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || rsp0_valid || rsp1_valid || op_count !== 8'(m_count)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_no_issue busy=%b v0=%b cnt=%0d exp busy=0 v0=0 cnt=%0d", busy, rsp0_valid, op_count, m_count);
        end
        tick;
    endtask

    task automatic test_counter_wrap;
        int hs_id, lat, rsp_id, exp_id;
        logic [7:0] prod;
        bit v0, v1, to, both, seen_max, seen_wrap;
        seen_max = 1'b0; seen_wrap = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v1 = 1'b1;
            exp_id = m_pick(v0, v1);
            run_op(v0, v1, 4'd1, 4'd1, 4'd1, 4'd1, hs_id, lat, rsp_id, prod, to, both);
            m_last = exp_id; m_count = (m_count + 1) % 256;
            checks++;
            if (to || rsp_id != exp_id || prod !== 8'd1 || op_count !== 8'(m_count)) begin
                failures++;
                $display("FAIL wrap[%0d] to=%0d rsp=%0d prod=%0d cnt=%0d exp rsp=%0d prod=1 cnt=%0d",
                         i, to, rsp_id, prod, op_count, exp_id, m_count);
            end
            if (op_count == 8'd255) seen_max = 1'b1;
            if (seen_max && op_count == 8'd0) seen_wrap = 1'b1;
        end
        checks++;
        if (!seen_wrap) begin failures++; $display("FAIL wrap_seen got=%0d exp=255_then_0", seen_max); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        rst_n = 1'b0;
        test_reset;
        test_simultaneous;
        test_single;
        test_back_pressure;
        test_random;
        test_reset_mid;
        test_withdrawal;
        test_counter_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Sequential controller that shares one combinational `bit4multiplier` between two requesters. It uses valid/ready handshakes and round-robin arbitration, and returns each registered 8-bit product on the requester's own response channel. It sits between the ALU front-end issue ports and the single 4×4 multiplier instance, so the multiplier is never driven by two sources at once.

## Interface
- `WIDTH`, 4, operand width; fixed at 4 to match `bit4multiplier`; the product is `2*WIDTH` bits.
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: requester 0 has operands.
- `req0_ready` out 1: arbiter accepts requester 0 this cycle.
- `req0_a` in WIDTH: requester 0 multiplicand.
- `req0_b` in WIDTH: requester 0 multiplier.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp0_valid` out 1: product ready for requester 0.
- `rsp0_ready` in 1: requester 0 takes the product.
- `rsp0_product` out 2*WIDTH: product for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_product`: same as requester 0, for requester 1.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out CNT_W: number of completed responses; wraps modulo 2^CNT_W.

## Operation
- **FSM states:** IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE:**
  - Grant goes to the requester whose valid is high. If both are high, grant goes to the one not served last.
  - `reqX_ready` is combinational: `state==IDLE && grant==X && rst_n`. At most one ready is high in any cycle.
  - On handshake (valid & ready), latch a, b and the requester id, then go to CALC.
- **CALC:**
  - Latched operands drive `bit4multiplier`.
  - Its output is registered into the product register.
  - Go to RESP.
- **RESP:**
  - `rspX_valid` is high for the latched id only. `rspX_product` holds the registered product.
  - Valid and product stay stable until `rspX_ready`.
  - On response handshake: set last-served = id, increment `op_count`, go to IDLE.
- **Valid rules:** `rsp*_valid` never depends combinationally on `rsp*_ready`. A requester deasserting valid before ready is ignored; nothing is latched.
- **Round-robin pointer:** `last_served` resets to 1, so requester 0 wins the first tie.
- **Arithmetic:** unsigned; the full 8-bit product is returned; no overflow is possible (max 15×15 = 225).
- **Reset values:**
  - all `req*_ready` and `rsp*_valid` = 0
  - `rsp*_product` = 0, `busy` = 0, `op_count` = 0
  - state = IDLE, `last_served` = 1
- **Reset mid-operation:** the in-flight operation is discarded with no response, and the counter clears.
- **Unselected response port:** its product output is driven 0.

## Timing
- A request handshake on cycle N gives `rsp_valid` high from cycle N+2.
- Minimum issue interval is 3 cycles: request handshake, CALC, then response handshake with immediate ready.
- The earliest next `req_ready` is the cycle after the response handshake.
- Back-pressure on `rsp_ready` stalls RESP indefinitely. Both `req_ready` stay low meanwhile.
- A request arriving in CALC or RESP waits and is arbitrated on return to IDLE.
- `busy` is registered from state: high exactly in CALC and RESP.
- `op_count` updates the cycle after the response handshake and wraps 255 → 0.

## Structure
- Shared package `alu_pkg`:
  - state enum (IDLE/CALC/RESP)
  - `MUL_W` = 4
  - requester-id constants `REQ0` and `REQ1`
- One sub-module: the existing `bit4multiplier`, instantiated once with ports `multiplicand`, `multiplier_input` and `A_B` driven from the latched operands.
- Everything else (FSM, arbiter, registers, counter) is flat in this module.

## Test plan
- **Single request:** req0 a=3, b=2 handshake at cycle N, `rsp0_ready`=1 → `rsp0_valid` at N+2 with product 8'd6; `rsp1_valid` stays 0; `op_count`=1.
- **Simultaneous requests:** req0 (5,6) and req1 (7,2) both valid from reset → req0 served first with 30; req1 next with 14; third tie goes to req0 again.
- **Back-pressure:** req1 (15,15) with `rsp1_ready` low for 5 cycles → product 225 and valid held stable; no `req_ready` asserted; on ready, return to IDLE.
- **Reset mid-operation:** `rst_n` low in CALC after req0 (9,5) → all outputs zero immediately; no response for 45 after release; the next request works normally.
- **Counter wrap:** 256 back-to-back ops (e.g. 1×1) → `op_count` reads 255 then 0; products all 1.
- **Valid withdrawal:** `req0_valid` pulsed high while the arbiter is in RESP, then dropped before IDLE → no operation is issued and `op_count` is unchanged.
